// File: rtl/ntt_pair_feeder.sv
// Collects one N-point coefficient vector, then issues the N/2 butterfly operand
// pairs of the selected NTT stage, one per cycle, each with its twiddle ROM address.
module ntt_pair_feeder #(
  parameter int WIDTH = 18,
  parameter int LOG_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOG_N-1:0] stage,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [LOG_N-2:0] out_tw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  localparam int N = 1 << LOG_N;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LOG_N-1:0] WR_LAST  = LOG_N'(N - 1);
  localparam logic [LOG_N-2:0] K_LAST   = '1;
  localparam logic [LOG_N-1:0] S_MAX    = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-1:0] S_LIMIT  = LOG_N'(LOG_N);
  localparam logic [LOG_N-1:0] HALF_TOP = LOG_N'(N / 2);

  logic [1:0]       state;
  logic [LOG_N-1:0] wr_cnt;
  logic [LOG_N-2:0] k;
  logic [LOG_N-1:0] s_reg;
  logic [WIDTH-1:0] mem [N];

  logic             in_hs;
  logic             out_hs;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] mask;
  logic [LOG_N-1:0] k_ext;
  logic [LOG_N-1:0] idx_a;
  logic [LOG_N-1:0] idx_b;
  logic [LOG_N-2:0] tw;

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_ISSUE);
  assign done      = (state == S_DONE);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // half is a power of two, so g/o split is a mask: bits above o shift up by one
  // to skip the partner block, which is where idx_b lives (idx_a | half).
  assign half  = HALF_TOP >> s_reg;
  assign mask  = half - LOG_N'(1);
  assign k_ext = {1'b0, k};
  assign idx_a = ((k_ext & ~mask) << 1) | (k_ext & mask);
  assign idx_b = idx_a | half;
  assign tw    = (k & mask[LOG_N-2:0]) << s_reg;

  assign out_a  = out_valid ? mem[idx_a] : '0;
  assign out_b  = out_valid ? mem[idx_b] : '0;
  assign out_tw = out_valid ? tw : '0;

  always_ff @(posedge clk) begin
    if (in_hs) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LOAD;
      wr_cnt <= '0;
      k      <= '0;
      s_reg  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            if (wr_cnt == '0) s_reg <= (stage >= S_LIMIT) ? S_MAX : stage;
            if (wr_cnt == WR_LAST) begin
              wr_cnt <= '0;
              state  <= S_ISSUE;
            end else begin
              wr_cnt <= wr_cnt + LOG_N'(1);
            end
          end
        end
        S_ISSUE: begin
          if (out_hs) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k <= k + (LOG_N-1)'(1);
            end
          end
        end
        S_DONE:  state <= S_LOAD;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_pair_feeder.sv
// Directed bench for ntt_pair_feeder (WIDTH=18, LOG_N=4): stage indexing, saturation,
// backpressure, async reset mid-load/mid-issue and back-to-back vectors with gaps.
module tb_ntt_pair_feeder;

  logic        clk;
  logic        rst;
  logic [3:0]  stage;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_a;
  logic [17:0] out_b;
  logic [2:0]  out_tw;
  logic        out_valid;
  logic        out_ready;
  logic        done;

  int checks = 0;
  int errors = 0;

  ntt_pair_feeder #(.WIDTH(18), .LOG_N(4)) dut (
    .clk(clk), .rst(rst), .stage(stage), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b), .out_tw(out_tw),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pair for pair number kk of a stage, data x[i] = base + i.
  function automatic void exp_pair(input int st, input int kk, input int base,
                                   output logic [17:0] ea, output logic [17:0] eb,
                                   output logic [2:0] et);
    int half, g, o, ia;
    half = 8 >> st;
    g    = kk / half;
    o    = kk % half;
    ia   = 2 * g * half + o;
    ea   = 18'(base + ia);
    eb   = 18'(base + ia + half);
    et   = 3'((o << st) & 7);
  endfunction

  task automatic send_word(input logic [17:0] d, input logic [3:0] st);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    stage    = st;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Stage only matters on word 0; later words carry a different value that must be ignored.
  task automatic load_vec(input logic [3:0] st, input int base, input bit gap);
    for (int i = 0; i < 16; i++) begin
      send_word(18'(base + i), (i == 0) ? st : ~st);
      if (gap && i < 15) @(posedge clk);
    end
  endtask

  task automatic check_pairs(input int st, input int base, input bit bp,
                             input bit hold_in, input int max_pairs);
    int kk, cyc;
    logic [17:0] ea, eb;
    logic [2:0]  et;
    kk  = 0;
    cyc = 0;
    while (kk < max_pairs && cyc < 200) begin
      @(negedge clk);
      out_ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (hold_in) begin
        in_valid = 1'b1;
        in_data  = 18'h3FFFF;
      end
      exp_pair(st, kk, base, ea, eb, et);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
          out_a !== ea || out_b !== eb || out_tw !== et) begin
        errors++;
        $display("FAIL pair st=%0d k=%0d: got v=%b in_rdy=%b done=%b a=%0d b=%0d tw=%0d, want v=1 in_rdy=0 done=0 a=%0d b=%0d tw=%0d",
                 st, kk, out_valid, in_ready, done, out_a, out_b, out_tw, ea, eb, et);
      end
      if (out_ready) kk++;
      cyc++;
    end
    if (kk < max_pairs) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got %0d pairs, want %0d", kk, max_pairs);
    end
    if (max_pairs == 8) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
          out_a !== 18'd0 || out_b !== 18'd0 || out_tw !== 3'd0) begin
        errors++;
        $display("FAIL done_cycle: got done=%b v=%b in_rdy=%b a=%0d b=%0d tw=%0d, want 1 0 0 0 0 0",
                 done, out_valid, in_ready, out_a, out_b, out_tw);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_done: got done=%b in_rdy=%b v=%b, want 0 1 0", done, in_ready, out_valid);
      end
    end
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 ||
        out_a !== 18'd0 || out_b !== 18'd0 || out_tw !== 3'd0) begin
      errors++;
      $display("FAIL %s: got in_rdy=%b v=%b done=%b a=%0d b=%0d tw=%0d, want 1 0 0 0 0 0",
               name, in_ready, out_valid, done, out_a, out_b, out_tw);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 ||
        out_a !== 18'd0 || out_b !== 18'd0 || out_tw !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got in_rdy=%b v=%b done=%b a=%0d b=%0d tw=%0d, want 1 0 0 0 0 0",
               in_ready, out_valid, done, out_a, out_b, out_tw);
    end
    rst = 1'b0;
  endtask

  task automatic test_stage0();
    load_vec(4'd0, 100, 1'b0);
    check_pairs(0, 100, 1'b0, 1'b0, 8);
  endtask

  task automatic test_stage1();
    load_vec(4'd1, 100, 1'b0);
    check_pairs(1, 100, 1'b0, 1'b0, 8);
  endtask

  task automatic test_stage3_saturate();
    load_vec(4'd3, 100, 1'b0);
    check_pairs(3, 100, 1'b0, 1'b0, 8);
    load_vec(4'd9, 100, 1'b0);
    check_pairs(3, 100, 1'b0, 1'b0, 8);
  endtask

  task automatic test_backpressure();
    load_vec(4'd0, 100, 1'b0);
    check_pairs(0, 100, 1'b1, 1'b1, 8);
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 5; i++) send_word(18'(500 + i), 4'd2);
    async_reset("reset_mid_load");
    test_stage0();
    load_vec(4'd1, 700, 1'b0);
    check_pairs(1, 700, 1'b0, 1'b0, 3);
    async_reset("reset_mid_issue");
    test_stage0();
  endtask

  task automatic test_back_to_back();
    load_vec(4'd1, 200, 1'b1);
    check_pairs(1, 200, 1'b0, 1'b0, 8);
    load_vec(4'd2, 300, 1'b1);
    check_pairs(2, 300, 1'b0, 1'b0, 8);
  endtask

  initial begin
    rst       = 1'b1;
    stage     = 4'd0;
    in_data   = 18'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_stage0();
    test_stage1();
    test_stage3_saturate();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_pair_feeder.md
Name: ntt_pair_feeder

Overview:
Upstream feeder for the radix-2 multiply-mod/butterfly stage. It collects one N-point coefficient vector from a serial valid/ready stream into a local register array. It then issues the N/2 butterfly operand pairs for one selected NTT stage, one pair per cycle, each with its twiddle index. The twiddle index drives the weight ROM that supplies weight_1/weight_2 to the downstream butterfly.

Parameters:
WIDTH, 18, coefficient bit width (matches the downstream butterfly)
LOG_N, 4, log2 of transform size; N = 2**LOG_N, N/2 pairs per stage

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
stage  input  LOG_N  stage number s; sampled with the first accepted word of each vector
in_data  input  WIDTH  coefficient, natural order x[0]..x[N-1]
in_valid  input  1  in_data valid
in_ready  output  1  feeder accepts a word this cycle
out_a  output  WIDTH  first butterfly operand x[idx_a]
out_b  output  WIDTH  second butterfly operand x[idx_b]
out_tw  output  LOG_N-1  twiddle ROM address for this pair
out_valid  output  1  pair valid
out_ready  input  1  downstream accepts pair
done  output  1  one-cycle pulse after the last pair of a vector is accepted

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- State machine, LOAD/ISSUE/DONE:
  - LOAD: in_ready=1. On an in_valid&&in_ready handshake, write in_data to mem[wr_cnt] and increment wr_cnt. The handshake at wr_cnt==0 also latches stage into s_reg. The handshake at wr_cnt==N-1 moves to ISSUE and clears wr_cnt.
  - ISSUE: in_ready=0; in_valid is ignored and its data is not stored. out_valid=1. On an out_valid&&out_ready handshake, increment pair counter k. The handshake at k==N/2-1 moves to DONE and clears k.
  - DONE: lasts one cycle. done=1, out_valid=0, in_ready=0. Next state is LOAD.
- Pair indexing, with half = N >> (s_reg+1), g = k / half, o = k mod half:
  - idx_a = 2*g*half + o
  - idx_b = idx_a + half
  - out_tw = o << s_reg, truncated to LOG_N-1 bits
  - Implement with shifts and masks only; no dividers.
- Out-of-range stage: a sampled stage value >= LOG_N saturates to LOG_N-1.
- Output timing: out_a, out_b and out_tw are combinational reads of mem and the counters while in ISSUE. They are forced to 0 whenever out_valid=0.
- Backpressure: if out_ready=0, the pair, k and the outputs hold stable. There is no bubble insertion, so with out_ready held high, throughput is one pair per cycle.
- Latency: the first pair is valid in the cycle after the N-th input handshake. A full vector takes N input cycles + N/2 issue cycles + 1 DONE cycle at minimum.
- Reset values, async:
  - state=LOAD, wr_cnt=0, k=0, s_reg=0
  - in_ready=1 (combinational from state), out_valid=0, done=0, out_a=out_b=out_tw=0
  - mem contents are not reset; they are never observable until rewritten.
- Reset mid-operation: a partially loaded vector or partially issued stage is abandoned. After release, the next accepted word is treated as x[0].
- Simultaneous events: only one handshake side is active per state, so input and output never handshake in the same cycle.
- Arithmetic: the block only moves data, with no modular arithmetic. Counter widths are LOG_N bits for wr_cnt and LOG_N-1 bits for k. Both wrap to 0 only by the explicit clears above.

Test Plan:
1. N=16, stage=0, x[i]=i+100, out_ready=1 → pairs (100,108),(101,109)…(107,115); out_tw=0..7; done pulses once, one cycle after the 8th pair.
2. stage=1, same data → pairs (100,104)…(103,107), then (108,112)…(111,115); out_tw=0,2,4,6,0,2,4,6.
3. stage=3 → pairs (100,101),(102,103)…(114,115); out_tw=0 for every pair. Repeat with stage=9 → identical output (saturates to 3).
4. Backpressure: out_ready toggles 1,0,0,1,… during stage 0 → each pair held stable while ready is low; no pair skipped or duplicated; 8 handshakes total. in_valid held high during ISSUE → in_ready=0 and mem is unchanged.
5. Reset mid-run: assert rst after 5 input words or after 3 issued pairs → all outputs 0 and in_ready=1 immediately (asynchronous). A new 16-word vector then issues correctly per scenario 1.
6. Back-to-back vectors with in_valid gaps (valid every other cycle) → second vector loads only after DONE; stage is re-sampled on its first word; pairs are correct for both vectors.
